// File: rtl/vga_position_loader.sv
// vga_position_loader: once-per-frame loader of obstacle X / player Y from data RAM port B
module vga_position_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] POS_BASE = 16'h2000,
  parameter logic [9:0] VBLANK_LINE = 10'd480,
  parameter int READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_OBSTACLE_X = 16'd400,
  parameter logic [DATA_WIDTH-1:0] INIT_PLAYER_Y = 16'd200
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic [9:0]            hcount,
  input  logic [9:0]            vcount,
  input  logic                  load_en,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b,
  output logic [DATA_WIDTH-1:0] obstacle_x,
  output logic [DATA_WIDTH-1:0] player_y,
  output logic                  busy,
  output logic                  load_done,
  output logic [15:0]           frame_count
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, COMMIT} state_t;
  localparam logic [1:0] WAIT_LOAD = 2'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);
  state_t r_state, w_next;
  logic r_cond_q, r_idx, r_load_done, w_cond, w_start;
  logic [1:0] r_wait;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_shadow0, r_shadow1, r_obstacle_x, r_player_y;
  logic [15:0] r_frame_count;
  assign w_cond = (vcount == VBLANK_LINE) && (hcount == 10'd0);
  assign w_start = (r_state == IDLE) && w_cond && !r_cond_q && load_en;
  assign ram_addr_b = r_addr;
  assign obstacle_x = r_obstacle_x;
  assign player_y = r_player_y;
  assign busy = r_state != IDLE;
  assign load_done = r_load_done;
  assign frame_count = r_frame_count;
  // next-state: one ISSUE/WAIT/CAPTURE pass per word, then a single COMMIT
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_start ? ISSUE : IDLE;
      ISSUE:   w_next = (READ_LATENCY == 1) ? CAPTURE : WAIT;
      WAIT:    w_next = (r_wait == 2'd0) ? CAPTURE : WAIT;
      CAPTURE: w_next = r_idx ? COMMIT : ISSUE;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // control: state, trigger edge history, word index, wait counter, read address
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cond_q <= 1'b0;
      r_idx <= 1'b0;
      r_wait <= 2'd0;
      r_addr <= POS_BASE;
    end else begin
      r_state <= w_next;
      r_cond_q <= w_cond;
      if (w_start) begin
        r_idx <= 1'b0;
        r_addr <= POS_BASE;
      end
      if (r_state == ISSUE) r_wait <= WAIT_LOAD;
      if (r_state == WAIT) r_wait <= r_wait - 2'd1;
      if (r_state == CAPTURE && !r_idx) begin
        r_idx <= 1'b1;
        r_addr <= POS_BASE + 1'b1;
      end
    end
  end
  // data: shadow capture, then both positions committed together on one edge
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_shadow0 <= '0;
      r_shadow1 <= '0;
      r_obstacle_x <= INIT_OBSTACLE_X;
      r_player_y <= INIT_PLAYER_Y;
      r_load_done <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_load_done <= r_state == COMMIT;
      if (r_state == CAPTURE) begin
        r_shadow0 <= r_idx ? r_shadow0 : ram_q_b;
        r_shadow1 <= r_idx ? ram_q_b : r_shadow1;
      end
      if (r_state == COMMIT) begin
        r_obstacle_x <= r_shadow0;
        r_player_y <= r_shadow1;
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end
endmodule

// File: doc/vga_position_loader.md
Name: vga_position_loader

Overview:
- Upstream feeder for the VGA top level. Once per frame, at the start of vertical blank, it reads two position words (obstacle X, player Y) from port B of the shared data RAM.
- Both words go into shadow registers. Both outputs are then committed on the same edge, so sprites never tear mid-frame.
- Replaces the hard-wired obstacle_x/player_y constants and the inline loader FSM in the VGA top.

Parameters:
- ADDR_WIDTH, 16, width of ram_addr_b.
- DATA_WIDTH, 16, width of ram_q_b and the position outputs.
- POS_BASE, 16'h2000, RAM address of obstacle_x. player_y is at POS_BASE+1.
- VBLANK_LINE, 10'd480, vcount value at which vertical blank begins.
- READ_LATENCY, 1, RAM port-B cycles from address sampled to q valid (legal values 1..4).
- INIT_OBSTACLE_X, 16'd400, obstacle_x value after reset.
- INIT_PLAYER_Y, 16'd200, player_y value after reset.

Ports:
- sys_clk  in  1  50 MHz system clock (same clock that generates pix_clk).
- reset  in  1  asynchronous, active-high reset.
- hcount  in  10  horizontal pixel count from vga_control.
- vcount  in  10  vertical line count from vga_control.
- load_en  in  1  when 0, frame triggers are ignored and the outputs hold.
- ram_addr_b  out  ADDR_WIDTH  read address to data RAM port B (registered).
- ram_q_b  in  DATA_WIDTH  read data from data RAM port B.
- obstacle_x  out  DATA_WIDTH  committed obstacle X position.
- player_y  out  DATA_WIDTH  committed player Y position.
- busy  out  1  high whenever the FSM is not in IDLE.
- load_done  out  1  one-cycle pulse, coincident with the first cycle new positions are visible.
- frame_count  out  16  count of completed loads; wraps 0xFFFF->0x0000.

Behaviour:
Reset values (asynchronous reset):
- state=IDLE, ram_addr_b=POS_BASE.
- obstacle_x=INIT_OBSTACLE_X, player_y=INIT_PLAYER_Y.
- load_done=0, frame_count=0, busy=0.
- Shadow registers and index cleared; the trigger-history register is cleared.

Trigger:
- cond = (vcount==VBLANK_LINE && hcount==0). cond_q = cond registered on sys_clk.
- rise = cond & ~cond_q.
- cond is high for 2 sys_clk cycles per frame because the pixel clock is half rate. The edge detect guarantees exactly one trigger per frame.
- Start condition: rise & load_en while in IDLE. A rise in any other state is ignored.

FSM states (idx is a 1-bit word index):
- IDLE: when the start condition holds → ISSUE, with idx=0 and ram_addr_b<=POS_BASE.
- ISSUE: 1 cycle; ram_addr_b = POS_BASE+idx. If READ_LATENCY==1 → CAPTURE, else → WAIT.
- WAIT: lasts READ_LATENCY-1 cycles via a down-counter, then → CAPTURE.
- CAPTURE: 1 cycle; ram_q_b sampled at the closing edge into shadow[idx].
  - idx==0: → ISSUE with idx=1 and ram_addr_b<=POS_BASE+1.
  - idx==1: → COMMIT.
- COMMIT: 1 cycle. At its closing edge: obstacle_x<=shadow[0], player_y<=shadow[1], load_done<=1, frame_count<=frame_count+1; → IDLE.

Address and pulse rules:
- ram_addr_b holds constant from ISSUE through CAPTURE of the same word.
- ram_addr_b holds its last value while in IDLE.
- load_done deasserts on the following edge.

Latency:
- With rise high in cycle t0, new outputs and load_done are visible in cycle t0+4+2*READ_LATENCY (t6 for READ_LATENCY=1).
- With READ_LATENCY=1: t1 ISSUE, t2 CAPTURE, t3 ISSUE, t4 CAPTURE, t5 COMMIT.

Output stability:
- obstacle_x and player_y change only at the COMMIT edge and at reset. Intermediate reads never appear on the outputs.

Data rules:
- The full DATA_WIDTH word is passed through unmodified (no clipping).
- POS_BASE+1 wraps modulo 2^ADDR_WIDTH.

Boundary conditions:
- load_en deasserted mid-load: the load completes normally. load_en gates only the start.
- Reset asserted mid-load: the FSM returns to IDLE immediately. Outputs revert to the INIT values and no load_done is generated.
- Reset released while cond is high: cond_q=0, so a rise may be seen on the first cycle; that load is permitted.

Test Plan:
- Reset check: reset, then release → obstacle_x=400, player_y=200, frame_count=0, busy=0, ram_addr_b=0x2000.
- Basic load: RAM[0x2000]=0x0123, RAM[0x2001]=0x0045, sweep hcount/vcount to line 480 → one load; ram_addr_b sequence 0x2000 then 0x2001; obstacle_x=0x0123 and player_y=0x0045 change on the same edge, 6 cycles after rise; load_done high for exactly 1 cycle; frame_count=1.
- Single trigger per frame: hold cond high for 2 cycles, run 3 frames with changing RAM contents → exactly 3 load_done pulses, frame_count=3, outputs track each frame's RAM values.
- load_en gating: load_en=0 over one frame → no busy, outputs unchanged. Drop load_en to 0 during CAPTURE of word 0 → load still completes.
- Reset mid-operation: assert reset during the second ISSUE with RAM values 0x0111/0x0222 → outputs 400/200, no load_done. The next frame loads normally.
- Latency parameter: READ_LATENCY=3, RAM model delaying q by 3 cycles → values captured correctly; new outputs visible 10 cycles after rise. Separately, preset frame_count to 0xFFFF and complete one load → wraps to 0x0000.
